// File: rtl/chan_burst_err_inj_if.sv
// Symbol stream and channel-damage report bundle between the encoder side and
// the burst-error channel model.
interface chan_burst_err_inj_if;
  logic        enable_i;
  logic [1:0]  d_in;
  logic        valid_o;
  logic [1:0]  d_out;
  logic [1:0]  err_inj_o;
  logic [15:0] burst_ct_o;
  logic [15:0] bad_bit_ct_o;
  logic [15:0] word_ct_o;

  modport master (
    output enable_i, d_in,
    input  valid_o, d_out, err_inj_o, burst_ct_o, bad_bit_ct_o, word_ct_o
  );

  modport slave (
    input  enable_i, d_in,
    output valid_o, d_out, err_inj_o, burst_ct_o, bad_bit_ct_o, word_ct_o
  );
endinterface

// File: rtl/chan_burst_err_inj.sv
// Burst bit-error channel between convolutional encoder and Viterbi decoder.
// Define CHAN_ERR_RANDOM_EN to start bursts from the LFSR instead of word_ct.
module chan_burst_err_inj #(
  parameter int          N          = 4,
  parameter int          BURST_LEN  = 2,
  parameter int          WORD_LIMIT = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst,
  chan_burst_err_inj_if.slave bus
);

  // state | meaning
  // IDLE  | passing clean words, watching for a burst trigger
  // BURST | corrupting the remaining words of a started burst
  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0]  REM_INIT = 4'(BURST_LEN - 1);
  localparam logic [16:0] LIMIT    = 17'(WORD_LIMIT);

  state_t      state_q;
  logic [3:0]  rem_q;
  logic [15:0] lfsr_q;
  logic [15:0] word_ct_q;
  logic [15:0] burst_ct_q;
  logic [15:0] bad_bit_ct_q;
  logic        valid_q;
  logic [1:0]  d_out_q;
  logic [1:0]  err_q;

  logic [1:0]  pattern;
  logic        lfsr_fb;
  logic        trig;
  logic [16:0] bad_sum;
  logic [15:0] bad_bit_ct_d;
  logic [15:0] burst_ct_d;

  assign pattern = (lfsr_q[1:0] == 2'b00) ? 2'b11 : lfsr_q[1:0];
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

`ifdef CHAN_ERR_RANDOM_EN
  assign trig = (lfsr_q[15 -: N] == '0) && ({1'b0, word_ct_q} < LIMIT);
`else
  assign trig = (word_ct_q[N-1:0] == '1) && ({1'b0, word_ct_q} < LIMIT);
`endif

  // Both counters saturate rather than wrap.
  assign bad_sum      = {1'b0, bad_bit_ct_q} + {15'd0, pattern[1]} + {15'd0, pattern[0]};
  assign bad_bit_ct_d = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
  assign burst_ct_d   = (burst_ct_q == 16'hFFFF) ? burst_ct_q : burst_ct_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      word_ct_q    <= '0;
      burst_ct_q   <= '0;
      bad_bit_ct_q <= '0;
      valid_q      <= 1'b0;
      d_out_q      <= 2'b00;
      err_q        <= 2'b00;
    end else begin
      valid_q <= bus.enable_i;
      if (bus.enable_i) begin
        word_ct_q <= word_ct_q + 16'd1;
        lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
        case (state_q)
          IDLE: begin
            if (trig) begin
              d_out_q      <= bus.d_in ^ pattern;
              err_q        <= pattern;
              bad_bit_ct_q <= bad_bit_ct_d;
              burst_ct_q   <= burst_ct_d;
              rem_q        <= REM_INIT;
              state_q      <= (REM_INIT != 4'd0) ? BURST : IDLE;
            end else begin
              d_out_q <= bus.d_in;
              err_q   <= 2'b00;
            end
          end
          BURST: begin
            d_out_q      <= bus.d_in ^ pattern;
            err_q        <= pattern;
            bad_bit_ct_q <= bad_bit_ct_d;
            rem_q        <= rem_q - 4'd1;
            if (rem_q == 4'd1) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.d_out        = d_out_q;
  assign bus.err_inj_o    = err_q;
  assign bus.burst_ct_o   = burst_ct_q;
  assign bus.bad_bit_ct_o = bad_bit_ct_q;
  assign bus.word_ct_o    = word_ct_q;

endmodule

// File: tb/tb_chan_burst_err_inj.sv
// Randomized bench for chan_burst_err_inj: two instances (BURST_LEN=2/LIMIT=256
// and BURST_LEN=1/LIMIT=32) checked every cycle against a word-index model.
module tb_chan_burst_err_inj;

`ifdef CHAN_ERR_RANDOM_EN
  localparam int LIM0   = 16'hFFFF;
  localparam int WORDS_A = 4096;
`else
  localparam int LIM0   = 256;
  localparam int WORDS_A = 300;
`endif
  localparam int NN     = 4;
  localparam int BL[2]  = '{2, 1};
  localparam int LIM[2] = '{LIM0, 32};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] din = 2'b00;

  always #5 clk = ~clk;

  chan_burst_err_inj_if if0 ();
  chan_burst_err_inj_if if1 ();

  assign if0.enable_i = en;
  assign if0.d_in     = din;
  assign if1.enable_i = en;
  assign if1.d_in     = din;

  chan_burst_err_inj #(.N(NN), .BURST_LEN(2), .WORD_LIMIT(LIM0), .LFSR_SEED(16'hACE1))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  chan_burst_err_inj #(.N(NN), .BURST_LEN(1), .WORD_LIMIT(32), .LFSR_SEED(16'hACE1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic        a_valid[2];
  logic [1:0]  a_dout[2], a_err[2];
  logic [15:0] a_burst[2], a_bad[2], a_wc[2];
  assign a_valid[0] = if0.valid_o;      assign a_valid[1] = if1.valid_o;
  assign a_dout[0]  = if0.d_out;        assign a_dout[1]  = if1.d_out;
  assign a_err[0]   = if0.err_inj_o;    assign a_err[1]   = if1.err_inj_o;
  assign a_burst[0] = if0.burst_ct_o;   assign a_burst[1] = if1.burst_ct_o;
  assign a_bad[0]   = if0.bad_bit_ct_o; assign a_bad[1]   = if1.bad_bit_ct_o;
  assign a_wc[0]    = if0.word_ct_o;    assign a_wc[1]    = if1.word_ct_o;

  int checks = 0;
  int failures = 0;

  // Model: a word is corrupted while its index is below the end of the burst
  // in progress; otherwise a trigger on that index opens a new burst.
  logic        ev[2];
  logic [1:0]  edout[2], eerr[2];
  logic [15:0] m_wc[2], m_lfsr[2], m_bursts[2], m_bad[2];
  int          m_bend[2];

  logic [1:0]  log_err0[0:4095];
  logic [1:0]  log_err1[0:4095];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ev[i] = 0; edout[i] = 0; eerr[i] = 0;
      m_wc[i] = 0; m_lfsr[i] = 16'hACE1; m_bursts[i] = 0; m_bad[i] = 0; m_bend[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic e, input logic [1:0] d);
    int w;
    bit trig, corrupt;
    logic [1:0] p;
    ev[i] = e;
    if (!e) return;
    w = int'(m_wc[i]);
`ifdef CHAN_ERR_RANDOM_EN
    trig = ((m_lfsr[i] >> (16 - NN)) == 0) && (w < LIM[i]);
`else
    trig = ((w % (1 << NN)) == (1 << NN) - 1) && (w < LIM[i]);
`endif
    p = m_lfsr[i][1:0];
    if (p == 2'b00) p = 2'b11;
    corrupt = (w < m_bend[i]);
    if (!corrupt && trig) begin
      corrupt = 1;
      m_bend[i] = w + BL[i];
      if (m_bursts[i] != 16'hFFFF) m_bursts[i]++;
    end
    if (corrupt) begin
      eerr[i]  = p;
      edout[i] = d ^ p;
      m_bad[i] = (int'(m_bad[i]) + $countones(p) > 65535) ? 16'hFFFF : m_bad[i] + 16'($countones(p));
    end else begin
      eerr[i]  = 2'b00;
      edout[i] = d;
    end
    m_wc[i]   = m_wc[i] + 16'd1;
    m_lfsr[i] = lfsr_next(m_lfsr[i]);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 32'(a_valid[i]), 32'(ev[i]));
      chk($sformatf("d_out%0d", i), 32'(a_dout[i]), 32'(edout[i]));
      chk($sformatf("err_inj%0d", i), 32'(a_err[i]), 32'(eerr[i]));
      chk($sformatf("burst_ct%0d", i), 32'(a_burst[i]), 32'(m_bursts[i]));
      chk($sformatf("bad_bit_ct%0d", i), 32'(a_bad[i]), 32'(m_bad[i]));
      chk($sformatf("word_ct%0d", i), 32'(a_wc[i]), 32'(m_wc[i]));
      if (a_valid[i] === 1'b1)
        chk($sformatf("dout_vs_err%0d", i), 32'(a_dout[i] ^ a_err[i]), 32'(din));
    end
  endtask

  // One clock: inputs held across the edge, model stepped, outputs compared #1 later.
  task automatic cycle(input logic e, input logic [1:0] d);
    int w0, w1;
    w0 = int'(m_wc[0]); w1 = int'(m_wc[1]);
    en = e; din = d;
    @(posedge clk);
    model_step(0, e, d);
    model_step(1, e, d);
    #1;
    compare_all();
    if (e && w0 < 4096) log_err0[w0] = a_err[0];
    if (e && w1 < 4096) log_err1[w1] = a_err[1];
  endtask

  task automatic do_reset();
    en = 0;
    rst = 1;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst = 0;
  endtask

  int bad_sum;
  int vcount;

  initial begin
    model_reset();
    #3;
    compare_all();
    chk("reset_word_ct", 32'(a_wc[0]), 32'd0);
    chk("reset_valid", 32'(a_valid[0]), 32'd0);
    @(negedge clk);
    rst = 0;

    // Phase A: constant symbol 2'b10, every word valid.
    for (int k = 0; k < WORDS_A; k++) cycle(1'b1, 2'b10);
`ifndef CHAN_ERR_RANDOM_EN
    chk("A_burst_ct0", 32'(a_burst[0]), 32'd16);
    chk("A_burst_ct1", 32'(a_burst[1]), 32'd2);
    chk("A_word_ct0", 32'(a_wc[0]), 32'd300);
    chk("A_w14_clean", 32'(log_err0[14] != 0), 32'd0);
    chk("A_w15_hit", 32'(log_err0[15] != 0), 32'd1);
    chk("A_w16_hit", 32'(log_err0[16] != 0), 32'd1);
    chk("A_w17_clean", 32'(log_err0[17] != 0), 32'd0);
    chk("A_w255_hit", 32'(log_err0[255] != 0), 32'd1);
    chk("A_w256_hit", 32'(log_err0[256] != 0), 32'd1);
    chk("A_w257_clean", 32'(log_err0[257] != 0), 32'd0);
    chk("A_w271_clean", 32'(log_err0[271] != 0), 32'd0);
    chk("A1_w15_hit", 32'(log_err1[15] != 0), 32'd1);
    chk("A1_w16_clean", 32'(log_err1[16] != 0), 32'd0);
    chk("A1_w31_hit", 32'(log_err1[31] != 0), 32'd1);
    chk("A1_w47_clean", 32'(log_err1[47] != 0), 32'd0);
`endif
    bad_sum = 0;
    for (int k = 0; k < WORDS_A; k++) bad_sum += $countones(log_err0[k]);
    chk("A_bad_bit_sum", 32'(a_bad[0]), 32'(bad_sum));

    // Phase B: enable toggling 1,0,1,...
    do_reset();
    for (int k = 0; k < 40; k++) cycle((k % 2) == 0, 2'($urandom_range(3)));
    chk("B_word_ct", 32'(a_wc[0]), 32'd20);
`ifndef CHAN_ERR_RANDOM_EN
    chk("B_w14_clean", 32'(log_err0[14] != 0), 32'd0);
    chk("B_w15_hit", 32'(log_err0[15] != 0), 32'd1);
    chk("B_w16_hit", 32'(log_err0[16] != 0), 32'd1);
    chk("B_burst_ct", 32'(a_burst[0]), 32'd1);
`endif

    // Phase C: reset asserted while word 16 is presented (mid-burst).
    do_reset();
    for (int k = 0; k < 16; k++) cycle(1'b1, 2'($urandom_range(3)));
    en = 1; din = 2'b01;
    #2;
    rst = 1;
    model_reset();
    #1;
    compare_all();
    chk("C_rst_burst", 32'(a_burst[0]), 32'd0);
    chk("C_rst_err", 32'(a_err[0]), 32'd0);
    @(negedge clk);
    rst = 0;
    en = 0;
    for (int k = 0; k < 20; k++) cycle(1'b1, 2'($urandom_range(3)));
`ifndef CHAN_ERR_RANDOM_EN
    chk("C_w14_clean", 32'(log_err0[14] != 0), 32'd0);
    chk("C_w15_hit", 32'(log_err0[15] != 0), 32'd1);
`endif

    // Phase D: random enable and symbols.
    do_reset();
    vcount = 0;
    for (int k = 0; k < 2000; k++) begin
      logic e;
      e = ($urandom_range(3) != 0);
      if (e) vcount++;
      cycle(e, 2'($urandom_range(3)));
    end
    chk("D_word_ct", 32'(a_wc[0]), 32'(vcount));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
